// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle controller for the MIPS-subset datapath.
//
// It steps every instruction through IF -> ID -> [EXE -> [MEM] -> WB] and
// issues one-cycle write strobes for the IR, PC, register file and data
// memory. It also counts retired instructions.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   Instr[31:0]     IR contents (meaningful from ID onward)
//   RegDst[1:0]     00 rt, 01 rd, 10 $31
//   ALUSrc          1 = imm32 drives ALU B
//   MemtoReg[1:0]   00 ALU, 01 DM, 10 PC+4
//   ExtCtrl[1:0]    00 zero-ext, 01 sign-ext, 10 imm<<16
//   ALUOp[4:0]      0 add, 1 sub, 2 or
//   isBr/isJump/isJr/isMemb  NPC and DM mode selects
//   RegWrite, MemWrite, PCWrite, IRWrite  one-cycle write strobes
//   State[2:0]      IF=0, ID=1, EXE=2, MEM=3, WB=4 (debug/observe)
//   Retired         completed-instruction count, wraps silently
//
// Strobe semantics: each strobe is a single-cycle write enable. The datapath
// commits the write on the rising edge that ends the cycle in which the
// strobe is high. There is no back-pressure, so every state lasts exactly one cycle.
module mc_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Instr,
  output logic [1:0]          RegDst,
  output logic                ALUSrc,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ExtCtrl,
  output logic [4:0]          ALUOp,
  output logic                isBr,
  output logic                isJump,
  output logic                isJr,
  output logic                isMemb,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic [2:0]          State,
  output logic [RETIRE_W-1:0] Retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire;
  logic                rw, mw, pw, iw;

  // ---------------------------------------------------------------- decode
  logic [5:0] op, funct;
  assign op    = Instr[31:26];
  assign funct = Instr[5:0];

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_lb;
  logic is_sw, is_sb, is_beq, is_j, is_jal;
  logic is_load, is_store, is_short;

  assign is_addu = (op == 6'b000000) && (funct == 6'b100001);
  assign is_subu = (op == 6'b000000) && (funct == 6'b100011);
  assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_lb   = (op == 6'b100000);
  assign is_sw   = (op == 6'b101011);
  assign is_sb   = (op == 6'b101000);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  assign is_load  = is_lw | is_lb;
  assign is_store = is_sw | is_sb;
  // j, jal, jr, beq and every unrecognised word (nop) finish in ID.
  assign is_short = ~(is_addu | is_subu | is_ori | is_lui | is_load | is_store);

  // Instr[25:6] only carries register/immediate fields the datapath uses.
  logic unused_fields;
  assign unused_fields = ^Instr[25:6];

  // --------------------------------------------------------- static selects
  // Decoded purely from Instr and held for the whole instruction. They are
  // zero in IF and in the illegal encodings.
  always_comb begin
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 2'b00;
    ExtCtrl  = 2'b00;
    ALUOp    = 5'd0;
    isBr     = 1'b0;
    isJump   = 1'b0;
    isJr     = 1'b0;
    isMemb   = 1'b0;
    if (state_q inside {S_ID, S_EXE, S_MEM, S_WB}) begin
      if (is_addu || is_subu) RegDst = 2'b01;
      else if (is_jal)        RegDst = 2'b10;
      ALUSrc = is_ori | is_lui | is_load | is_store;
      if (is_load)     MemtoReg = 2'b01;
      else if (is_jal) MemtoReg = 2'b10;
      if (is_lui)                     ExtCtrl = 2'b10;
      else if (is_load || is_store)   ExtCtrl = 2'b01;
      if (is_subu)               ALUOp = 5'd1;
      else if (is_ori || is_lui) ALUOp = 5'd2;
      isBr   = is_beq;
      isJump = is_j | is_jal;
      isJr   = is_jr;
      isMemb = is_lb | is_sb;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    rw      = 1'b0;
    mw      = 1'b0;
    pw      = 1'b0;
    iw      = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IF: begin
        iw      = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_short) begin
          // jal links in ID: PC+4 still reflects the old PC this cycle.
          pw      = 1'b1;
          rw      = is_jal;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (is_store) begin
          mw      = 1'b1;
          pw      = 1'b1;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        pw      = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;  // encodings 5..7 recover with no strobes
    endcase
  end

  // Reset masks the strobes combinationally so an aborted instruction
  // cannot commit anything in the reset cycle itself.
  assign RegWrite = rw & ~reset;
  assign MemWrite = mw & ~reset;
  assign PCWrite  = pw & ~reset;
  assign IRWrite  = iw & ~reset;
  assign State    = state_q;

  // ------------------------------------------------------- retire counter
  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + RETIRE_W'(1);
  end

  assign Retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl. An independent per-instruction model pushes one
// expected control vector per cycle into exp_q; a negedge monitor pops and
// compares against the DUT outputs.
module tb_mc_ctrl;

  localparam int W = 23;  // {state3, rw, mw, pw, iw, sel16}

  typedef enum int {
    K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_LB,
    K_SW, K_SB, K_BEQ, K_J, K_JAL
  } kind_t;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instr = 32'h0;
  always #5 clk = ~clk;

  logic [1:0]  reg_dst, mem_to_reg, ext_ctrl;
  logic        alu_src, is_br, is_jump, is_jr, is_memb;
  logic [4:0]  alu_op;
  logic        reg_write, mem_write, pc_write, ir_write;
  logic [2:0]  state;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Instr(instr),
    .RegDst(reg_dst), .ALUSrc(alu_src), .MemtoReg(mem_to_reg),
    .ExtCtrl(ext_ctrl), .ALUOp(alu_op), .isBr(is_br), .isJump(is_jump),
    .isJr(is_jr), .isMemb(is_memb), .RegWrite(reg_write),
    .MemWrite(mem_write), .PCWrite(pc_write), .IRWrite(ir_write),
    .State(state), .Retired(retired)
  );

  // Narrow-counter instance to reach the wrap point in a few cycles.
  logic [1:0] n_reg_dst, n_mem_to_reg, n_ext_ctrl;
  logic       n_alu_src, n_is_br, n_is_jump, n_is_jr, n_is_memb;
  logic [4:0] n_alu_op;
  logic       n_reg_write, n_mem_write, n_pc_write, n_ir_write;
  logic [2:0] n_state;
  logic [3:0] n_retired;

  mc_ctrl #(.RETIRE_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .Instr(instr),
    .RegDst(n_reg_dst), .ALUSrc(n_alu_src), .MemtoReg(n_mem_to_reg),
    .ExtCtrl(n_ext_ctrl), .ALUOp(n_alu_op), .isBr(n_is_br),
    .isJump(n_is_jump), .isJr(n_is_jr), .isMemb(n_is_memb),
    .RegWrite(n_reg_write), .MemWrite(n_mem_write), .PCWrite(n_pc_write),
    .IRWrite(n_ir_write), .State(n_state), .Retired(n_retired)
  );

  // ------------------------------------------------------------ checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  function automatic kind_t kind_of(input logic [31:0] ins);
    kind_t k;
    k = K_NOP;
    case (ins[31:26])
      6'b000000: begin
        if (ins[5:0] == 6'b100001)      k = K_ADDU;
        else if (ins[5:0] == 6'b100011) k = K_SUBU;
        else if (ins[5:0] == 6'b001000) k = K_JR;
      end
      6'b001101: k = K_ORI;
      6'b001111: k = K_LUI;
      6'b100011: k = K_LW;
      6'b100000: k = K_LB;
      6'b101011: k = K_SW;
      6'b101000: k = K_SB;
      6'b000100: k = K_BEQ;
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      default:   k = K_NOP;
    endcase
    return k;
  endfunction

  // {RegDst, ALUSrc, MemtoReg, ExtCtrl, ALUOp, isBr, isJump, isJr, isMemb}
  function automatic logic [15:0] sel_of(input kind_t k);
    case (k)
      K_ADDU:  return {2'b01, 1'b0, 2'b00, 2'b00, 5'd0, 4'b0000};
      K_SUBU:  return {2'b01, 1'b0, 2'b00, 2'b00, 5'd1, 4'b0000};
      K_JR:    return {2'b00, 1'b0, 2'b00, 2'b00, 5'd0, 4'b0010};
      K_ORI:   return {2'b00, 1'b1, 2'b00, 2'b00, 5'd2, 4'b0000};
      K_LUI:   return {2'b00, 1'b1, 2'b00, 2'b10, 5'd2, 4'b0000};
      K_LW:    return {2'b00, 1'b1, 2'b01, 2'b01, 5'd0, 4'b0000};
      K_LB:    return {2'b00, 1'b1, 2'b01, 2'b01, 5'd0, 4'b0001};
      K_SW:    return {2'b00, 1'b1, 2'b00, 2'b01, 5'd0, 4'b0000};
      K_SB:    return {2'b00, 1'b1, 2'b00, 2'b01, 5'd0, 4'b0001};
      K_BEQ:   return {2'b00, 1'b0, 2'b00, 2'b00, 5'd0, 4'b1000};
      K_J:     return {2'b00, 1'b0, 2'b00, 2'b00, 5'd0, 4'b0100};
      K_JAL:   return {2'b10, 1'b0, 2'b10, 2'b00, 5'd0, 4'b0100};
      default: return 16'h0;
    endcase
  endfunction

  // State visited in cycle c of an instruction of kind k.
  function automatic logic [2:0] state_at(input kind_t k, input int c);
    logic [2:0] seq_short [2] = '{3'd0, 3'd1};
    logic [2:0] seq_alu   [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [2:0] seq_store [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] seq_load  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: return seq_alu[c];
      K_SW, K_SB:                   return seq_store[c];
      K_LW, K_LB:                   return seq_load[c];
      default:                      return seq_short[c];
    endcase
  endfunction

  function automatic int lat_of(input kind_t k);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW, K_SB: return 4;
      K_LW, K_LB:                               return 5;
      default:                                  return 2;
    endcase
  endfunction

  function automatic logic [W-1:0] vec_of(input kind_t k, input int c,
                                          input bit aborted);
    logic [2:0]  st;
    logic        rw, mw, pw, iw;
    logic [15:0] sel;
    bit          last;
    st   = state_at(k, c);
    last = (c == lat_of(k) - 1);
    iw   = (c == 0);
    pw   = last;
    mw   = last && (k == K_SW || k == K_SB);
    rw   = (last && st == 3'd4) || (k == K_JAL && c == 1);
    sel  = (c == 0) ? 16'h0 : sel_of(k);
    if (aborted) begin
      rw = 1'b0; mw = 1'b0; pw = 1'b0; iw = 1'b0;
    end
    return {st, rw, mw, pw, iw, sel};
  endfunction

  // ----------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           exp_ret = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {state, reg_write, mem_write, pc_write, ir_write,
                reg_dst, alu_src, mem_to_reg, ext_ctrl, alu_op,
                is_br, is_jump, is_jr, is_memb}, e);
    end
  end

  // ---------------------------------------------------------------- driver
  // Entered just after a rising edge with the DUT in IF. abort_at >= 0
  // raises reset during that cycle of the instruction.
  task automatic run_instr(input logic [31:0] ins, input int abort_at);
    kind_t k;
    k = kind_of(ins);
    instr = ins;
    for (int c = 0; c < lat_of(k); c++) begin
      if (c == abort_at) begin
        reset = 1'b1;
        exp_q.push_back(vec_of(k, c, 1'b1));
        tag_q.push_back($sformatf("abort %08h c%0d", ins, c));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ret = 0;
        check("abort_state", state, 3'd0);
        check("abort_ret", retired, 0);
        return;
      end
      exp_q.push_back(vec_of(k, c, 1'b0));
      tag_q.push_back($sformatf("ins %08h c%0d", ins, c));
      @(posedge clk); #1;
    end
    exp_ret++;
    check($sformatf("ret %08h", ins), retired, exp_ret);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 12))
      0:  return {6'b000000, r[25:6], 6'b100001};
      1:  return {6'b000000, r[25:6], 6'b100011};
      2:  return {6'b000000, r[25:6], 6'b001000};
      3:  return {6'b001101, r[25:0]};
      4:  return {6'b001111, 5'd0, r[20:0]};
      5:  return {6'b100011, r[25:0]};
      6:  return {6'b100000, r[25:0]};
      7:  return {6'b101011, r[25:0]};
      8:  return {6'b101000, r[25:0]};
      9:  return {6'b000100, r[25:0]};
      10: return {6'b000010, r[25:0]};
      11: return {6'b000011, r[25:0]};
      default: return {6'b111111, r[25:0]};  // unknown opcode -> nop
    endcase
  endfunction

  // ------------------------------------------------------------- sequence
  initial begin
    // Reset for two cycles: strobes must stay low even though State is IF.
    @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_strobes", {reg_write, mem_write, pc_write, ir_write}, 4'b0000);
    check("rst_ret", retired, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_strobes2", {reg_write, mem_write, pc_write, ir_write}, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two nops, then the directed instructions.
    run_instr(32'h0000_0000, -1);
    run_instr(32'h0000_0000, -1);
    check("nop_ret2", retired, 2);
    run_instr(32'h0022_1821, -1);  // addu $3,$1,$2
    run_instr(32'h8C04_0008, -1);  // lw $4,8($0)
    run_instr(32'hA004_0003, -1);  // sb $4,3($0)
    run_instr(32'h0C00_0300, -1);  // jal 0x00000C00
    run_instr(32'h0000_0020, -1);  // add (unsupported) -> nop

    for (int i = 0; i < 40; i++) run_instr(rand_instr(), -1);

    // Reset during WB of ori.
    run_instr(32'h3422_0005, 3);
    check("w4_ret_rst", n_retired, 4'd0);

    // Narrow counter wrap.
    for (int i = 0; i < 15; i++) run_instr(32'h0000_0000, -1);
    check("w4_ret_max", n_retired, 4'hF);
    run_instr(32'h0000_0000, -1);
    check("w4_ret_wrap", n_retired, 4'h0);
    check("ret_after_wrap", retired, 16);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle controller that drives the control inputs of the single-cycle datapath once it is converted to multi-cycle operation (an IR register and a PC write enable are added to it).
- Decodes the latched instruction word and steps through fetch, decode, execute, memory and writeback phases.
- Issues one-cycle write strobes per phase and counts retired instructions.
- Sits directly upstream of the datapath.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Instr  in  32  IR contents from the datapath; valid from ID onward
- RegDst  out  2  00 rt, 01 rd, 10 $31
- ALUSrc  out  1  1 selects imm32 as ALU B input
- MemtoReg  out  2  00 ALU, 01 DM, 10 PC+4
- ExtCtrl  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- ALUOp  out  5  0 add, 1 sub, 2 or; all other values unused
- isBr, isJump, isJr, isMemb  out  1 each  NPC and DM mode selects
- RegWrite  out  1  GRF write strobe
- MemWrite  out  1  DM write strobe
- PCWrite  out  1  PC <= NPC strobe
- IRWrite  out  1  IR <= IM[PC] strobe
- State  out  3  IF=0, ID=1, EXE=2, MEM=3, WB=4
- Retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Reset values:
  - State = IF and Retired = 0.
  - RegWrite, MemWrite, PCWrite and IRWrite are forced to 0 during every cycle in which reset is high, regardless of State.
  - Reset mid-instruction aborts it; no partial writes occur.
- Decode table (op / funct):
  - addu 000000/100001, subu 000000/100011, jr 000000/001000
  - ori 001101, lui 001111, lw 100011, lb 100000, sw 101011, sb 101000
  - beq 000100, j 000010, jal 000011
  - Anything else, including all-zero, is treated as a nop.
- Static selects:
  - RegDst, ALUSrc, MemtoReg, ExtCtrl, ALUOp, isBr, isJump, isJr and isMemb are decoded from Instr.
  - They are held constant from ID until the instruction's last state.
  - They are 0 in IF.
  - isMemb = 1 only for lb and sb.
- IF: IRWrite = 1, then go to ID.
- ID:
  - j: PCWrite = 1 with isJump = 1.
  - jal: RegWrite = 1 and PCWrite = 1 with isJump = 1, RegDst = 10, MemtoReg = 10. The PC+4 captured is the old PC, because PC updates at the same edge.
  - jr: PCWrite = 1 with isJr = 1.
  - beq: PCWrite = 1 with isBr = 1; the datapath's comparison decides between taken and PC+4.
  - nop: PCWrite = 1.
  - For j, jal, jr, beq and nop the next state is IF and the instruction retires.
  - All other instructions go to EXE.
- EXE:
  - addu: ALUOp 0, RegDst 01.
  - subu: ALUOp 1, RegDst 01.
  - ori: ALUOp 2, ALUSrc 1, ExtCtrl 00.
  - lui: ALUOp 2, ALUSrc 1, ExtCtrl 10. rs is $0, so the result is imm<<16.
  - lw, lb, sw, sb: ALUOp 0, ALUSrc 1, ExtCtrl 01.
  - Loads and stores go to MEM; the rest go to WB.
- MEM:
  - sw, sb: MemWrite = 1 and PCWrite = 1, then go to IF and retire.
  - lw, lb: go to WB.
- WB:
  - RegWrite = 1 and PCWrite = 1, then go to IF and retire.
  - MemtoReg is 01 for loads and 00 otherwise; RegDst is 00 for I-type.
- Retired:
  - Increments by 1 on the edge that leaves an instruction's final state.
  - Wraps modulo 2^RETIRE_W with no flag.
- Latency (cycles per instruction):
  - j, jal, jr, beq, nop: 2
  - addu, subu, ori, lui, sw, sb: 4
  - lw, lb: 5
- Strobe exclusivity:
  - PCWrite is asserted exactly once per instruction.
  - MemWrite and RegWrite are never both high.
  - IRWrite is never high outside IF.
- Illegal State encodings 5 to 7 go to IF on the next cycle with all strobes 0.

Test Plan:
1. Reset for 2 cycles, then release with Instr = 0 (nop). Required: State sequence 0,1,0,1; PCWrite high only in ID cycles; Retired = 2 after 4 cycles.
2. addu $3,$1,$2 (0x00221821). Required: states 0,1,2,4; in WB RegWrite = 1, PCWrite = 1, RegDst = 01, MemtoReg = 00, ALUOp = 0; Retired +1.
3. lw $4,8($0) (0x8C040008), then sb (0xA0040003). Required for lw: 5 cycles, MemtoReg = 01 in WB, ExtCtrl = 01, isMemb = 0. Required for sb: 4 cycles, MemWrite = 1 only in MEM, isMemb = 1, RegWrite never high.
4. jal 0x00000C00 (0x0C000300). Required: 2 cycles; in ID RegWrite = 1, PCWrite = 1, isJump = 1, RegDst = 10, MemtoReg = 10.
5. Assert reset while in WB of an ori. Required: that cycle has RegWrite = 0 and PCWrite = 0; the next cycle has State = 0; Retired = 0.
6. Preload Retired to all-ones via 2^32−1 nops (or force the counter), then one more nop. Required: Retired = 0.
